// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM states, default timing constants and counter sizing
package btn_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;
  localparam int DEB_CYCLES_DEF = 500000;
  localparam int REPEAT_START_DEF = 25000000;
  localparam int REPEAT_PERIOD_DEF = 5000000;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-FF synchroniser, debounce FSM and one-cycle press pulse for one active-low button
module debounce_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W = cnt_width(DEB_CYCLES_DEF, REPEAT_START_DEF, REPEAT_PERIOD_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic pulse_o
);
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEB_CYCLES);
  localparam logic INSTANT = DEB_CYCLES <= 1;
  logic s1_q, s2_q, clean_q, clean_d, pulse_q, pulse_d, done;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  deb_state_t state_q, state_d;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign done = cnt_inc >= DEB;
  // the counter holds the number of stable samples seen so far, so the change is accepted on the sample that makes it DEB
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clean_d = clean_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (!s2_q) begin
        state_d = INSTANT ? HELD : PRESS_WAIT;
        cnt_d = INSTANT ? '0 : CNT_W'(1);
        clean_d = ~INSTANT;
        pulse_d = INSTANT;
      end
      PRESS_WAIT: begin
        state_d = s2_q ? IDLE : (done ? HELD : PRESS_WAIT);
        cnt_d = (s2_q || done) ? '0 : cnt_inc;
        clean_d = ~(!s2_q && done);
        pulse_d = !s2_q && done;
      end
      HELD: if (s2_q) begin
        state_d = INSTANT ? IDLE : RELEASE_WAIT;
        cnt_d = INSTANT ? '0 : CNT_W'(1);
        clean_d = INSTANT;
      end
      RELEASE_WAIT: begin
        state_d = !s2_q ? HELD : (done ? IDLE : RELEASE_WAIT);
        cnt_d = (!s2_q || done) ? '0 : cnt_inc;
        clean_d = s2_q && done;
      end
      default: begin
        state_d = IDLE;
        cnt_d = '0;
        clean_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      clean_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      pulse_q <= pulse_d;
    end
  end
  assign clean_o = clean_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces the decrement/reset buttons, adds decrement auto-repeat and reset-over-decrement priority
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REPEAT_START = REPEAT_START_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  parameter int CNT_W = cnt_width(DEB_CYCLES, REPEAT_START, REPEAT_PERIOD)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_decrement_raw,
  input  logic btn_reset_raw,
  output logic btn_decrement,
  output logic btn_reset,
  output logic dec_pulse,
  output logic rst_pulse
);
  logic dec_clean, dec_press, rst_clean, rst_press, held;
  logic seen_q, seen_d, rep_q, rep_d;
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc, hold_tgt;
  debounce_channel #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_dec (
    .clk(clk), .rst(rst), .raw_i(btn_decrement_raw), .clean_o(dec_clean), .pulse_o(dec_press)
  );
  debounce_channel #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_rst (
    .clk(clk), .rst(rst), .raw_i(btn_reset_raw), .clean_o(rst_clean), .pulse_o(rst_press)
  );
  // hold_q restarts after every repeat, so it is compared against the start delay first and the period afterwards
  always_comb begin
    held = ~dec_clean & rst_clean;
    hold_inc = &hold_q ? hold_q : hold_q + 1'b1;
    hold_tgt = seen_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_START);
    rep_d = held & (hold_inc == hold_tgt);
    hold_d = (held & ~rep_d) ? hold_inc : '0;
    seen_d = held & (seen_q | rep_d);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= '0;
      seen_q <= 1'b0;
      rep_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      seen_q <= seen_d;
      rep_q <= rep_d;
    end
  end
  assign btn_decrement = dec_clean | ~rst_clean | rep_q;
  assign dec_pulse = rst_clean & (dec_press | (rep_q & ~dec_clean));
  assign btn_reset = rst_clean;
  assign rst_pulse = rst_press;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: table-driven vectors plus hand-written auto-repeat and reset-mid-press sequences
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst, dr, rr, bd, br, dp, rp;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  btn_conditioner #(.DEB_CYCLES(4), .REPEAT_START(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .btn_decrement_raw(dr), .btn_reset_raw(rr),
    .btn_decrement(bd), .btn_reset(br), .dec_pulse(dp), .rst_pulse(rp)
  );
  typedef struct {
    logic d;
    logic r;
    logic n;
    logic [3:0] e;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic d, input logic r, input logic n, input logic [3:0] e, input int cnt);
    for (int i = 0; i < cnt; i++) tv.push_back('{d, r, n, e});
  endtask
  task automatic step(input logic d, input logic r, input logic n, input logic [3:0] e, input string nm, input int idx);
    dr = d;
    rr = r;
    rst = n;
    @(posedge clk);
    #1;
    nvec++;
    if ({bd, br, dp, rp} !== e) begin
      nerr++;
      $display("FAIL %s[%0d]: bd/br/dp/rp got %b expected %b", nm, idx, {bd, br, dp, rp}, e);
    end
  endtask
  function automatic logic [3:0] rep_exp(input int c);
    logic rep;
    rep = c >= 25 && c < 65 && (c - 25) % 8 == 0;
    return {c < 5 || c >= 65 || rep, 1'b1, c == 5 || rep, 1'b0};
  endfunction
  function automatic logic [3:0] mid_exp(input int c);
    if (c < 5 || (c >= 30 && c < 36) || c >= 46) return 4'b1100;
    if (c == 5 || c == 36) return 4'b0110;
    if (c == 25) return 4'b1110;
    return 4'b0100;
  endfunction
  initial begin
    int npulse;
    dr = 1'b0;
    rr = 1'b0;
    rst = 1'b0;
    add(0, 0, 0, 4'b1100, 2);
    add(0, 0, 1, 4'b1100, 5);
    add(0, 0, 1, 4'b1001, 1);
    add(0, 0, 1, 4'b1000, 4);
    add(1, 1, 1, 4'b1000, 5);
    add(1, 1, 1, 4'b1100, 1);
    add(0, 1, 1, 4'b1100, 3);
    add(1, 1, 1, 4'b1100, 6);
    add(0, 1, 1, 4'b1100, 5);
    add(0, 1, 1, 4'b0110, 1);
    add(0, 1, 1, 4'b0100, 4);
    add(1, 1, 1, 4'b0100, 5);
    add(1, 1, 1, 4'b1100, 3);
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 1, 4'b1100, 2);
      add(1, 1, 1, 4'b1100, 2);
    end
    add(0, 1, 1, 4'b1100, 5);
    add(0, 1, 1, 4'b0110, 1);
    add(0, 1, 1, 4'b0100, 2);
    add(1, 1, 1, 4'b0100, 5);
    add(1, 1, 1, 4'b1100, 3);
    for (int i = 0; i < tv.size(); i++) step(tv[i].d, tv[i].r, tv[i].n, tv[i].e, "table", i);
    npulse = 0;
    for (int c = 0; c <= 70; c++) begin
      step(c < 60 ? 1'b0 : 1'b1, 1'b1, 1'b1, rep_exp(c), "repeat", c);
      npulse += int'(dp === 1'b1);
    end
    nvec++;
    if (npulse != 6) begin
      nerr++;
      $display("FAIL repeat_count: got %0d pulses expected 6", npulse);
    end
    for (int c = 0; c <= 47; c++) step(c <= 40 ? 1'b0 : 1'b1, 1'b1, c == 30 ? 1'b0 : 1'b1, mid_exp(c), "midreset", c);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
